// File: rtl/uart_cfg_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cfg_if
//  Brief    : Host-side byte handshake bundle for uart_cfg (TX and RX paths).
//  Revision : 1.0  initial release
// ============================================================================
interface uart_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_break;
    logic                 rx_overrun;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data,
        input  rx_frame_err, rx_parity_err, rx_break, rx_overrun
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data,
        output rx_frame_err, rx_parity_err, rx_break, rx_overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cfg
//  Brief    : Runtime-configurable UART: programmable divisor, parity, stop
//             bits; 3-sample majority RX with per-byte status flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  wire             clk,
    input  wire             rst,
    input  wire [DIV_W-1:0] divisor,
    input  wire [1:0]       parity_mode,
    input  wire             stop2,
    input  wire             rx,
    output logic            tx,
    output logic            tx_busy,
    output logic            rx_busy,
    uart_cfg_if.slave       bus
);
    localparam int c_OS_W  = $clog2(OVERSAMPLE);
    localparam int c_IDX_W = $clog2(DATA_BITS);
    localparam logic [c_OS_W-1:0]  c_OS_LAST  = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_OS_W-1:0]  c_SMP_A    = c_OS_W'(OVERSAMPLE / 2 - 2);
    localparam logic [c_OS_W-1:0]  c_SMP_B    = c_OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OS_W-1:0]  c_SMP_C    = c_OS_W'(OVERSAMPLE / 2);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    // ---------------------------------------------------------------- TX ----
    state_t               r_tx_state, w_tx_state_nxt;
    logic [DIV_W-1:0]     r_tx_cnt;
    logic [c_OS_W-1:0]    r_tx_os;
    logic [c_IDX_W-1:0]   r_tx_idx, w_tx_idx_nxt;
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 r_tx_par, r_tx_par_en, r_tx_stop2, r_tx;
    logic                 w_tx_accept, w_tx_tick, w_tx_bit_end, w_tx_nxt;

    assign w_tx_accept  = (r_tx_state == S_IDLE) && bus.tx_valid;
    assign w_tx_tick    = (r_tx_state != S_IDLE) && (r_tx_cnt == '0);
    assign w_tx_bit_end = w_tx_tick && (r_tx_os == c_OS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_cnt <= '0;
            r_tx_os  <= '0;
        end else if (w_tx_accept) begin
            r_tx_cnt <= divisor;
            r_tx_os  <= '0;
        end else if (w_tx_tick) begin
            r_tx_cnt <= divisor;
            r_tx_os  <= w_tx_bit_end ? '0 : r_tx_os + 1'b1;
        end else if (r_tx_state != S_IDLE) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_idx_nxt   = r_tx_idx;
        case (r_tx_state)
            S_IDLE:   if (bus.tx_valid) begin
                          w_tx_state_nxt = S_START;
                          w_tx_idx_nxt   = '0;
                      end
            S_START:  if (w_tx_bit_end) w_tx_state_nxt = S_DATA;
            S_DATA:   if (w_tx_bit_end) begin
                          if (r_tx_idx == c_IDX_LAST) begin
                              w_tx_idx_nxt   = '0;
                              w_tx_state_nxt = r_tx_par_en ? S_PARITY : S_STOP;
                          end else begin
                              w_tx_idx_nxt = r_tx_idx + 1'b1;
                          end
                      end
            S_PARITY: if (w_tx_bit_end) w_tx_state_nxt = S_STOP;
            S_STOP:   if (w_tx_bit_end) begin
                          // idx doubles as the stop-bit counter
                          if (r_tx_stop2 && (r_tx_idx == '0)) begin
                              w_tx_idx_nxt = 1'b1;
                          end else begin
                              w_tx_idx_nxt   = '0;
                              w_tx_state_nxt = S_IDLE;
                          end
                      end
            default:  w_tx_state_nxt = S_IDLE;
        endcase

        case (w_tx_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_tx_data[w_tx_idx_nxt];
            S_PARITY: w_tx_nxt = r_tx_par;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state  <= S_IDLE;
            r_tx_idx    <= '0;
            r_tx        <= 1'b1;
            r_tx_data   <= '0;
            r_tx_par    <= 1'b0;
            r_tx_par_en <= 1'b0;
            r_tx_stop2  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx       <= w_tx_nxt;
            if (w_tx_accept) begin
                r_tx_data   <= bus.tx_data;
                r_tx_par    <= (^bus.tx_data) ^ (parity_mode == 2'b01);
                r_tx_par_en <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                r_tx_stop2  <= stop2;
            end
        end
    end

    assign tx           = r_tx;
    assign tx_busy      = (r_tx_state != S_IDLE);
    assign bus.tx_ready = (r_tx_state == S_IDLE);

    // ---------------------------------------------------------------- RX ----
    state_t               r_rx_state, w_rx_state_nxt;
    logic                 r_rx_s1, r_rx_s2, r_rx_prev;
    logic [DIV_W-1:0]     r_rx_cnt;
    logic [c_OS_W-1:0]    r_rx_os;
    logic [c_IDX_W-1:0]   r_rx_idx;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [1:0]           r_rx_smp;
    logic                 r_rx_odd, r_rx_par_en, r_rx_any_one, r_rx_par_err;
    logic                 w_rx_start, w_rx_run, w_rx_tick, w_rx_bit_end;
    logic                 w_rx_smp, w_rx_mid, w_rx_maj_evt, w_rx_maj, w_rx_load;

    assign w_rx_start   = (r_rx_state == S_IDLE) && r_rx_prev && !r_rx_s2;
    assign w_rx_run     = (r_rx_state != S_IDLE) && (r_rx_state != S_WAIT);
    assign w_rx_tick    = w_rx_run && (r_rx_cnt == '0);
    assign w_rx_bit_end = w_rx_tick && (r_rx_os == c_OS_LAST);
    assign w_rx_smp     = w_rx_tick && ((r_rx_os == c_SMP_A) || (r_rx_os == c_SMP_B) ||
                                        (r_rx_os == c_SMP_C));
    assign w_rx_mid     = w_rx_tick && (r_rx_os == c_SMP_B);
    assign w_rx_maj_evt = w_rx_tick && (r_rx_os == c_SMP_C);
    assign w_rx_maj     = (r_rx_smp[1] & r_rx_smp[0]) | (r_rx_smp[1] & r_rx_s2) |
                          (r_rx_smp[0] & r_rx_s2);
    // The byte is handed over at the middle stop sample so that the next
    // start edge can be caught even with a fast transmitter.
    assign w_rx_load    = (r_rx_state == S_STOP) && w_rx_mid;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            S_IDLE:   if (w_rx_start) w_rx_state_nxt = S_START;
            S_START:  if (w_rx_maj_evt && w_rx_maj) w_rx_state_nxt = S_IDLE;
                      else if (w_rx_bit_end)        w_rx_state_nxt = S_DATA;
            S_DATA:   if (w_rx_bit_end && (r_rx_idx == c_IDX_LAST))
                          w_rx_state_nxt = r_rx_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_rx_bit_end) w_rx_state_nxt = S_STOP;
            S_STOP:   if (w_rx_mid) w_rx_state_nxt = r_rx_s2 ? S_IDLE : S_WAIT;
            S_WAIT:   if (r_rx_s2) w_rx_state_nxt = S_IDLE;
            default:  w_rx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= S_IDLE;
            r_rx_cnt     <= '0;
            r_rx_os      <= '0;
            r_rx_idx     <= '0;
            r_rx_shift   <= '0;
            r_rx_smp     <= '0;
            r_rx_odd     <= 1'b0;
            r_rx_par_en  <= 1'b0;
            r_rx_any_one <= 1'b0;
            r_rx_par_err <= 1'b0;
        end else begin
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_nxt;

            if (w_rx_start) begin
                r_rx_cnt     <= divisor;
                r_rx_os      <= '0;
                r_rx_idx     <= '0;
                r_rx_any_one <= 1'b0;
                r_rx_par_err <= 1'b0;
                r_rx_odd     <= (parity_mode == 2'b01);
                r_rx_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            end else if (w_rx_tick) begin
                r_rx_cnt <= divisor;
                r_rx_os  <= w_rx_bit_end ? '0 : r_rx_os + 1'b1;
            end else if (w_rx_run) begin
                r_rx_cnt <= r_rx_cnt - 1'b1;
            end

            if (w_rx_smp) r_rx_smp <= {r_rx_smp[0], r_rx_s2};

            if (w_rx_maj_evt && (r_rx_state == S_DATA)) begin
                r_rx_shift   <= {w_rx_maj, r_rx_shift[DATA_BITS-1:1]};
                r_rx_any_one <= r_rx_any_one | w_rx_maj;
            end
            if (w_rx_maj_evt && (r_rx_state == S_PARITY)) begin
                r_rx_par_err <= w_rx_maj ^ (^r_rx_shift) ^ r_rx_odd;
                r_rx_any_one <= r_rx_any_one | w_rx_maj;
            end
            if (w_rx_bit_end && (r_rx_state == S_DATA)) r_rx_idx <= r_rx_idx + 1'b1;
        end
    end

    // Holding register: a freshly completed frame always wins over the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rx_valid      <= 1'b0;
            bus.rx_data       <= '0;
            bus.rx_frame_err  <= 1'b0;
            bus.rx_parity_err <= 1'b0;
            bus.rx_break      <= 1'b0;
            bus.rx_overrun    <= 1'b0;
        end else if (w_rx_load) begin
            bus.rx_valid      <= 1'b1;
            bus.rx_data       <= r_rx_shift;
            bus.rx_frame_err  <= !r_rx_s2;
            bus.rx_parity_err <= r_rx_par_err;
            bus.rx_break      <= !r_rx_s2 && !r_rx_any_one;
            bus.rx_overrun    <= bus.rx_valid && !bus.rx_ready;
        end else if (bus.rx_valid && bus.rx_ready) begin
            bus.rx_valid      <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
            bus.rx_parity_err <= 1'b0;
            bus.rx_break      <= 1'b0;
            bus.rx_overrun    <= 1'b0;
        end
    end

    assign rx_busy = (r_rx_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cfg
//  Brief    : Directed + randomized bench for uart_cfg with a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_cfg;
    localparam int DB = 8;
    localparam int OS = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] divisor;
    logic [1:0]    parity_mode;
    logic          stop2;
    logic          rx_drv;
    logic          loop;
    logic          rx_pin;
    logic          tx, tx_busy, rx_busy;

    always #5 clk = ~clk;

    uart_cfg_if #(.DATA_BITS(DB)) bus ();

    assign rx_pin = loop ? tx : rx_drv;

    uart_cfg #(.DATA_BITS(DB), .OVERSAMPLE(OS), .DIV_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .divisor     (divisor),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .rx          (rx_pin),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .rx_busy     (rx_busy),
        .bus         (bus)
    );

    typedef struct packed {
        logic [DB-1:0] d;
        logic          fe;
        logic          pe;
        logic          brk;
        logic          ovr;
    } rec_t;

    int   checks   = 0;
    int   failures = 0;
    rec_t q[$];

    // Every completed handshake becomes a received record.
    always @(negedge clk)
        if (!rst && bus.rx_valid && bus.rx_ready)
            q.push_back({bus.rx_data, bus.rx_frame_err, bus.rx_parity_err,
                         bus.rx_break, bus.rx_overrun});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int bit_t();
        return OS * (int'(divisor) + 1);
    endfunction

    function automatic logic par_of(input logic [DB-1:0] d, input logic [1:0] pm);
        return (^d) ^ (pm == 2'b01);
    endfunction

    // Frame-level expectation from the bits that appear on the line.
    function automatic rec_t model(input logic [DB-1:0] d, input logic [1:0] pm,
                                   input logic pbit, input logic stopv, input logic ovr);
        rec_t r;
        logic pen;
        pen   = (pm == 2'b01) || (pm == 2'b10);
        r.d   = d;
        r.fe  = ~stopv;
        r.pe  = pen && (pbit != par_of(d, pm));
        r.brk = ~stopv && (d == '0) && !(pen && pbit);
        r.ovr = ovr;
        return r;
    endfunction

    task automatic drive_frame(input logic [DB-1:0] d, input logic [1:0] pm,
                               input logic pbit, input logic stopv);
        int t;
        t = bit_t();
        rx_drv = 1'b0;
        cyc(t);
        for (int i = 0; i < DB; i++) begin
            rx_drv = d[i];
            cyc(t);
        end
        if ((pm == 2'b01) || (pm == 2'b10)) begin
            rx_drv = pbit;
            cyc(t);
        end
        rx_drv = stopv;
        cyc(t);
        rx_drv = 1'b1;
    endtask

    task automatic expect_rx(input string tag, input rec_t e);
        int   n;
        rec_t g;
        n = 0;
        while (q.size() == 0 && n < 5000) begin
            cyc(1);
            n++;
        end
        g = 'x;
        if (q.size() > 0) g = q.pop_front();
        check(tag, 32'(g), 32'(e));
    endtask

    task automatic count_low(output int low);
        low = 0;
        while (bus.tx_ready !== 1'b1 && low < 20000) begin
            cyc(1);
            low++;
        end
    endtask

    task automatic tx_send(input logic [DB-1:0] d, output int low);
        int n;
        n = 0;
        while (bus.tx_ready !== 1'b1 && n < 20000) begin
            cyc(1);
            n++;
        end
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        cyc(1);
        bus.tx_valid = 1'b0;
        count_low(low);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int            low, n, t, total, pen;
        logic [DB-1:0] d;
        logic [1:0]    pm;
        logic          pbit, stopv, seen;

        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.rx_ready = 1'b1;
        divisor      = 16'd2;
        parity_mode  = 2'b00;
        stop2        = 1'b0;
        rx_drv       = 1'b1;
        loop         = 1'b0;
        rst          = 1'b1;
        cyc(4);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_flags", 32'({bus.rx_frame_err, bus.rx_parity_err, bus.rx_break,
                                bus.rx_overrun}), 32'd0);
        check("rst_busy", 32'({tx_busy, rx_busy}), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Back-to-back loopback, 8N1 at divisor 2
        loop = 1'b1;
        q.delete();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hA5;
        cyc(1);
        bus.tx_data  = 8'h3C;
        count_low(low);
        check("b2b_len_a5", 32'(low), 32'(10 * 48));
        cyc(1);
        bus.tx_valid = 1'b0;
        count_low(low);
        check("b2b_len_3c", 32'(low), 32'(10 * 48));
        expect_rx("lb_a5", model(8'hA5, 2'b00, 1'b0, 1'b1, 1'b0));
        expect_rx("lb_3c", model(8'h3C, 2'b00, 1'b0, 1'b1, 1'b0));

        // Randomized loopback across divisor, parity and stop settings
        for (int k = 0; k < 4; k++) begin
            cyc(4);
            divisor     = 16'($urandom_range(1, 3));
            parity_mode = 2'($urandom_range(0, 3));
            stop2       = 1'($urandom_range(0, 1));
            d           = DB'($urandom);
            pen         = ((parity_mode == 2'b01) || (parity_mode == 2'b10)) ? 1 : 0;
            q.delete();
            tx_send(d, low);
            check("rnd_lb_len", 32'(low), 32'((1 + DB + pen + (stop2 ? 2 : 1)) * bit_t()));
            expect_rx("rnd_lb_rx", model(d, parity_mode, par_of(d, parity_mode), 1'b1, 1'b0));
        end

        // Driven RX frames: even parity 0x81 wrong then right, then random ones
        loop        = 1'b0;
        divisor     = 16'd2;
        stop2       = 1'b0;
        parity_mode = 2'b10;
        cyc(10);
        q.delete();
        drive_frame(8'h81, 2'b10, ~par_of(8'h81, 2'b10), 1'b1);
        expect_rx("par_bad_81", model(8'h81, 2'b10, ~par_of(8'h81, 2'b10), 1'b1, 1'b0));
        cyc(bit_t());
        drive_frame(8'h81, 2'b10, par_of(8'h81, 2'b10), 1'b1);
        expect_rx("par_ok_81", model(8'h81, 2'b10, par_of(8'h81, 2'b10), 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) begin
            cyc(2 * bit_t());
            pm          = 2'($urandom_range(0, 3));
            parity_mode = pm;
            d           = DB'($urandom);
            pbit        = par_of(d, pm) ^ 1'($urandom_range(0, 1));
            stopv       = ($urandom_range(0, 3) != 0);
            drive_frame(d, pm, pbit, stopv);
            expect_rx("rnd_rx", model(d, pm, pbit, stopv, 1'b0));
        end

        // Break: line low for two frame times
        cyc(2 * bit_t());
        parity_mode = 2'b00;
        t = bit_t();
        q.delete();
        rx_drv = 1'b0;
        cyc(2 * 10 * t);
        check("brk_one_byte", 32'(q.size()), 32'd1);
        rx_drv = 1'b1;
        cyc(2 * t);
        expect_rx("brk_rec", model(8'h00, 2'b00, 1'b0, 1'b0, 1'b0));
        check("brk_no_more", 32'(q.size()), 32'd0);

        // Glitch: one tick low
        cyc(t);
        q.delete();
        rx_drv = 1'b0;
        cyc(int'(divisor) + 1);
        rx_drv = 1'b1;
        total = int'(divisor) + 1;
        seen  = rx_busy;
        n = 0;
        while ((rx_busy === 1'b1 || (!seen && n < 4)) && n < 4 * t) begin
            cyc(1);
            n++;
            if (rx_busy === 1'b1) seen = 1'b1;
        end
        check("glitch_busy_seen", 32'(seen), 32'd1);
        check("glitch_idle_in_T", 32'((total + n) <= t), 32'd1);
        cyc(2 * t);
        check("glitch_no_byte", 32'(q.size()), 32'd0);

        // Overrun with rx_ready held low
        bus.rx_ready = 1'b0;
        drive_frame(8'h11, 2'b00, 1'b0, 1'b1);
        cyc(t);
        check("ovr_first_valid", 32'(bus.rx_valid), 32'd1);
        check("ovr_first_rec", 32'({bus.rx_data, bus.rx_frame_err, bus.rx_parity_err,
                                    bus.rx_break, bus.rx_overrun}),
              32'(model(8'h11, 2'b00, 1'b0, 1'b1, 1'b0)));
        drive_frame(8'h22, 2'b00, 1'b0, 1'b1);
        cyc(t);
        check("ovr_second_rec", 32'({bus.rx_data, bus.rx_frame_err, bus.rx_parity_err,
                                     bus.rx_break, bus.rx_overrun}),
              32'(model(8'h22, 2'b00, 1'b0, 1'b1, 1'b1)));
        bus.rx_ready = 1'b1;
        cyc(1);
        check("ovr_pop_valid", 32'(bus.rx_valid), 32'd0);
        check("ovr_pop_flags", 32'({bus.rx_frame_err, bus.rx_parity_err, bus.rx_break,
                                    bus.rx_overrun}), 32'd0);
        q.delete();

        // Reset in the middle of data bit 3, then a 0x55 8O2 frame
        loop         = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = DB'($urandom);
        cyc(1);
        bus.tx_valid = 1'b0;
        cyc(4 * t + t / 2 - 1);
        rst = 1'b1;
        cyc(1);
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_tx_ready", 32'(bus.tx_ready), 32'd1);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        parity_mode = 2'b01;
        stop2       = 1'b1;
        q.delete();
        tx_send(8'h55, low);
        check("post_rst_len", 32'(low), 32'(12 * t));
        expect_rx("post_rst_rx", model(8'h55, 2'b01, par_of(8'h55, 2'b01), 1'b1, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
